// File: rtl/gf_mult_arbiter.sv
// gf_mult_arbiter: shares one digit-serial GF(2^Width) multiplier core between
// NumReq requesters with round-robin arbitration and a valid/ready response.
// Build option: define GF_MULT_ARB_SCRUB_EN to clear operand and product
// registers on each response handshake and to mask prod_o while no response
// is valid, so key-dependent data does not linger.

// Digit-serial multiplier: StagesPerCycle bits of B per cycle, MSB first.
module gf_mult_core #(
    parameter int unsigned      Width          = 32,
    parameter int unsigned      StagesPerCycle = 8,
    parameter logic [Width-1:0] IPoly          = 'h8299
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    output logic             ack_o,
    output logic [Width-1:0] prod_o
);
    localparam int unsigned Loops = Width / StagesPerCycle;
    localparam int unsigned CntW  = (Loops > 1) ? $clog2(Loops) : 1;

    logic [CntW-1:0]           cnt_q;
    logic [Width-1:0]          acc_q;
    logic [Width-1:0]          acc_d;
    logic [StagesPerCycle-1:0] digit;

    // Multiply by x modulo the field polynomial.
    function automatic logic [Width-1:0] mul_x(input logic [Width-1:0] v);
        return {v[Width-2:0], 1'b0} ^ (v[Width-1] ? IPoly : '0);
    endfunction

    // Horner step over one digit; the first digit starts from a clean accumulator.
    always_comb begin
        digit = StagesPerCycle'(op_b_i >> ((Loops - 1 - 32'(cnt_q)) * StagesPerCycle));
        acc_d = (cnt_q == '0) ? '0 : acc_q;
        for (int j = StagesPerCycle - 1; j >= 0; j--) begin
            acc_d = mul_x(acc_d) ^ (digit[j] ? op_a_i : '0);
        end
    end

    assign ack_o  = req_i && (cnt_q == CntW'(Loops - 1));
    assign prod_o = acc_d;

    // Digit counter and accumulator; the counter only clears on reset or its own ack.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (req_i) begin
            cnt_q <= ack_o ? '0 : cnt_q + 1'b1;
            acc_q <= acc_d;
        end
    end
endmodule

module gf_mult_arbiter #(
    parameter int unsigned      NumReq         = 2,
    parameter int unsigned      Width          = 32,
    parameter int unsigned      StagesPerCycle = 8,
    parameter logic [Width-1:0] IPoly          = 'h8299
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NumReq-1:0]              req_i,
    input  logic [NumReq-1:0][Width-1:0]   operand_a_i,
    input  logic [NumReq-1:0][Width-1:0]   operand_b_i,
    output logic [NumReq-1:0]              gnt_o,
    output logic                           rsp_valid_o,
    output logic [$clog2(NumReq)-1:0]      rsp_id_o,
    output logic [Width-1:0]               prod_o,
    input  logic                           rsp_ready_i,
    output logic                           busy_o
);
    localparam int unsigned IdW = $clog2(NumReq);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e           state_q;
    logic [IdW-1:0]   rr_ptr_q;
    logic [IdW-1:0]   id_q;
    logic [IdW-1:0]   winner;
    logic [IdW-1:0]   idx;
    logic             any_req;
    logic             grant;
    logic [Width-1:0] op_a_q;
    logic [Width-1:0] op_b_q;
    logic [Width-1:0] prod_q;
    logic [Width-1:0] core_prod;
    logic             core_ack;
    int unsigned      k;

    // Round-robin search: first pending request at or after rr_ptr_q, wrapping.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        k       = 0;
        idx     = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k = 32'(rr_ptr_q) + i;
            if (k >= NumReq) begin
                k = k - NumReq;
            end
            idx = IdW'(k);
            if (!any_req && req_i[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    assign grant = (state_q == IDLE) && any_req;

    // No grant pulse can escape while reset is held.
    assign gnt_o = (grant && rst_ni) ? (NumReq'(1) << winner) : '0;

    gf_mult_core #(
        .Width          (Width),
        .StagesPerCycle (StagesPerCycle),
        .IPoly          (IPoly)
    ) u_core (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (state_q == BUSY),
        .op_a_i (op_a_q),
        .op_b_i (op_b_q),
        .ack_o  (core_ack),
        .prod_o (core_prod)
    );

    // Sequencer: grant and latch in IDLE, hold the core for one product, then respond.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q  <= BUSY;
                        id_q     <= winner;
                        op_a_q   <= operand_a_i[winner];
                        op_b_q   <= operand_b_i[winner];
                        rr_ptr_q <= (winner == IdW'(NumReq - 1)) ? '0 : winner + 1'b1;
                    end
                end
                BUSY: begin
                    if (core_ack) begin
                        prod_q  <= core_prod;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q <= IDLE;
`ifdef GF_MULT_ARB_SCRUB_EN
                        op_a_q  <= '0;
                        op_b_q  <= '0;
                        prod_q  <= '0;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid_o = (state_q == RESP);
    assign busy_o      = (state_q != IDLE);
    assign rsp_id_o    = id_q;
`ifdef GF_MULT_ARB_SCRUB_EN
    assign prod_o      = rsp_valid_o ? prod_q : '0;
`else
    assign prod_o      = prod_q;
`endif
endmodule
